color_blob_detector: RTL and testbench
======================================

Name: color_blob_detector

Overview:
- Upstream producer of the colour-tracking interface: classifies each incoming camera pixel as strong red, green or blue, and accumulates a per-colour pixel count and bounding box over the active frame.
- At end of frame it selects the dominant colour and drives detected / xtrack / ytrack as held levels, updated once per frame, into the gesture tracker that sets the output colour.
- Sits between the camera pixel pipeline and the tracker, all in the 65 MHz pixel clock domain.

Parameters:
- H_ACTIVE, 1024, active pixels per line; pixels with hcount_in >= H_ACTIVE are ignored.
- V_ACTIVE, 768, active lines; end of frame is hcount_in==0 && vcount_in==V_ACTIVE.
- THRESH_HI, 160, minimum value of the dominant channel.
- THRESH_LO, 80, maximum value of each of the other two channels.
- MIN_PIXELS, 64, minimum count for a colour to be reported.
- CNT_W, 20, per-colour counter width; counter saturates.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  reset.
- hcount_in  in  11  pixel x.
- vcount_in  in  10  pixel y.
- pixel_in  in  24  RGB 8:8:8, red in [23:16].
- pixel_valid_in  in  1  pixel_in is valid this cycle.
- detected  out  2  00 none, 01 red, 10 green, 11 blue; held level.
- xtrack  out  11  bounding-box x midpoint; held.
- ytrack  out  10  bounding-box y midpoint; held.
- frame_done_out  out  1  one-cycle pulse when outputs update.

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset values: detected=0, xtrack=0, ytrack=0, frame_done_out=0, state=ACCUM.
  - Counts clear to 0, xmin/ymin to all-ones, xmax/ymax to 0.
  - The first report after reset covers a partial frame.
- Classification (combinational):
  - red: R>=THRESH_HI, G<=THRESH_LO, B<=THRESH_LO; green and blue are analogous.
  - At most one class can match.
- States: ACCUM -> EVAL -> REPORT -> CLEAR -> ACCUM.
- ACCUM:
  - A matched pixel updates its colour only when pixel_valid_in=1, hcount_in<H_ACTIVE and vcount_in<V_ACTIVE.
  - Update: count+1, saturating at 2^CNT_W-1; xmin=min, xmax=max, ymin=min, ymax=max.
  - The end-of-frame condition moves to EVAL. That pixel position is outside the active area, so no pixel is lost.
- EVAL (1 cycle):
  - Winner is the colour with the largest count. Ties resolve red > green > blue.
  - If the winning count < MIN_PIXELS, the winner is none.
- REPORT (1 cycle):
  - detected <= winner code.
  - If winner != none: xtrack <= (xmin+xmax)>>1 using a 12-bit sum; ytrack <= (ymin+ymax)>>1 using an 11-bit sum.
  - If winner == none: xtrack and ytrack hold their previous values.
  - frame_done_out=1 for this cycle only.
- CLEAR (1 cycle): all accumulators return to reset values, then ACCUM.
- Latency: outputs change on the 3rd clock edge after the first end-of-frame cycle. They then hold until the next frame's REPORT.
- End-of-frame persistence: if the end-of-frame condition persists, it must not retrigger. ACCUM arms only after vcount_in != V_ACTIVE or hcount_in != 0 has been seen since CLEAR.
- Reset mid-operation: from any state, return immediately to reset values.

Decomposition:
- Shared package tracker_pkg holds:
  - colour codes DET_NONE=2'b00, DET_R=2'b01, DET_G=2'b10, DET_B=2'b11;
  - the detector state enum;
  - the coordinate widths (11 and 10).
- Tracker and detector share the colour codes.
- One sub-module, blob_accum: count plus bounding box for one colour, with clear and update inputs. It is instantiated three times.

Test Plan:
- Solid (255,0,0) square, x 100..199, y 50..149, rest black -> 3 cycles after (0,768): detected=01, xtrack=149, ytrack=99, frame_done_out one cycle.
- Green 10x10 (100 px) plus blue 20x20 (400 px) at x 300..319, y 200..219 -> detected=11, xtrack=309, ytrack=209.
- 63 red pixels with the previous report (01,149,99) -> detected=00, xtrack=149, ytrack=99 held, frame_done_out still pulses.
- Red and green each exactly 100 px -> detected=01 (tie priority).
- Filtering: pixels (200,200,0) and (255,0,0) with pixel_valid_in=0 must not be counted. Red pixels at hcount_in=1100 must also not be counted. Result -> detected=00.
- Filtering: a count forced to saturate (CNT_W=4, 20 px) -> stays 15 and remains the winner.
- rst_in pulsed mid-frame during ACCUM -> outputs 0 asynchronously. The next frame reports only pixels seen after reset release.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared colour codes, detector state encoding and coordinate widths for the
// colour-tracking path (detector and gesture tracker).
package tracker_pkg;

   localparam int X_W = 11;
   localparam int Y_W = 10;

   localparam logic [1:0] DET_NONE = 2'b00;
   localparam logic [1:0] DET_R    = 2'b01;
   localparam logic [1:0] DET_G    = 2'b10;
   localparam logic [1:0] DET_B    = 2'b11;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_EVAL   = 2'd1,
      ST_REPORT = 2'd2,
      ST_CLEAR  = 2'd3
   } det_state_t;

   // Thresholds keep the classes disjoint, so the if-chain order is irrelevant.
   function automatic logic [1:0] classify_pixel(input logic [23:0] px,
                                                 input logic [7:0]  hi,
                                                 input logic [7:0]  lo);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      r = px[23:16];
      g = px[15:8];
      b = px[7:0];
      if (r >= hi && g <= lo && b <= lo) begin
         classify_pixel = DET_R;
      end else if (g >= hi && r <= lo && b <= lo) begin
         classify_pixel = DET_G;
      end else if (b >= hi && r <= lo && g <= lo) begin
         classify_pixel = DET_B;
      end else begin
         classify_pixel = DET_NONE;
      end
   endfunction

endpackage

// File: rtl/color_blob_detector_if.sv
// Pixel stream in, per-frame colour report out. The camera side is the
// master; the detector is the slave.
interface color_blob_detector_if;
   import tracker_pkg::*;

   logic [X_W-1:0] hcount_in;
   logic [Y_W-1:0] vcount_in;
   logic [23:0]    pixel_in;
   logic           pixel_valid_in;
   logic [1:0]     detected;
   logic [X_W-1:0] xtrack;
   logic [Y_W-1:0] ytrack;
   logic           frame_done_out;

   modport master (
      output hcount_in, vcount_in, pixel_in, pixel_valid_in,
      input  detected, xtrack, ytrack, frame_done_out
   );

   modport slave (
      input  hcount_in, vcount_in, pixel_in, pixel_valid_in,
      output detected, xtrack, ytrack, frame_done_out
   );
endinterface

// File: rtl/blob_accum.sv
// Saturating pixel count plus bounding box for a single colour class.
module blob_accum
   import tracker_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_upd,
   input  logic [X_W-1:0]   i_x,
   input  logic [Y_W-1:0]   i_y,
   output logic [CNT_W-1:0] o_count,
   output logic [X_W-1:0]   o_xmin,
   output logic [X_W-1:0]   o_xmax,
   output logic [Y_W-1:0]   o_ymin,
   output logic [Y_W-1:0]   o_ymax
);

   logic [CNT_W-1:0] r_count;
   logic [X_W-1:0]   r_xmin;
   logic [X_W-1:0]   r_xmax;
   logic [Y_W-1:0]   r_ymin;
   logic [Y_W-1:0]   r_ymax;

   // Box keeps growing after the count saturates.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
         r_xmin  <= '1;
         r_xmax  <= '0;
         r_ymin  <= '1;
         r_ymax  <= '0;
      end else if (i_clr) begin
         r_count <= '0;
         r_xmin  <= '1;
         r_xmax  <= '0;
         r_ymin  <= '1;
         r_ymax  <= '0;
      end else if (i_upd) begin
         r_count <= (r_count == {CNT_W{1'b1}}) ? r_count : r_count + CNT_W'(1);
         r_xmin  <= (i_x < r_xmin) ? i_x : r_xmin;
         r_xmax  <= (i_x > r_xmax) ? i_x : r_xmax;
         r_ymin  <= (i_y < r_ymin) ? i_y : r_ymin;
         r_ymax  <= (i_y > r_ymax) ? i_y : r_ymax;
      end
   end

   assign o_count = r_count;
   assign o_xmin  = r_xmin;
   assign o_xmax  = r_xmax;
   assign o_ymin  = r_ymin;
   assign o_ymax  = r_ymax;

endmodule

// File: rtl/color_blob_detector.sv
// Classifies pixels as strong R/G/B, accumulates per-colour count and box over
// the active frame, and reports the dominant colour once per frame.
module color_blob_detector
   import tracker_pkg::*;
#(
   parameter int H_ACTIVE   = 1024,
   parameter int V_ACTIVE   = 768,
   parameter int THRESH_HI  = 160,
   parameter int THRESH_LO  = 80,
   parameter int MIN_PIXELS = 64,
   parameter int CNT_W      = 20
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   color_blob_detector_if.slave  cam
);

   localparam logic [X_W-1:0]   H_LIM   = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0]   V_LIM   = Y_W'(V_ACTIVE);
   localparam logic [7:0]       HI      = 8'(THRESH_HI);
   localparam logic [7:0]       LO      = 8'(THRESH_LO);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

   det_state_t       r_state;
   det_state_t       w_next;
   logic             r_armed;
   logic [1:0]       r_winner;
   logic [1:0]       r_detected;
   logic [X_W-1:0]   r_xtrack;
   logic [Y_W-1:0]   r_ytrack;
   logic             r_frame_done;

   logic [1:0]       w_class;
   logic             w_eof;
   logic             w_in_area;
   logic             w_clr;
   logic [2:0]       w_upd;
   logic [1:0]       w_lead;
   logic [CNT_W-1:0] w_best;
   logic [1:0]       w_winner;
   logic [1:0]       w_sel;
   logic [X_W:0]     w_xsum;
   logic [Y_W:0]     w_ysum;
   logic [X_W-1:0]   w_xmid;
   logic [Y_W-1:0]   w_ymid;

   logic [CNT_W-1:0] w_cnt  [3];
   logic [X_W-1:0]   w_xmin [3];
   logic [X_W-1:0]   w_xmax [3];
   logic [Y_W-1:0]   w_ymin [3];
   logic [Y_W-1:0]   w_ymax [3];

   assign w_class   = classify_pixel(cam.pixel_in, HI, LO);
   assign w_eof     = (cam.hcount_in == '0) && (cam.vcount_in == V_LIM);
   assign w_in_area = cam.pixel_valid_in && (cam.hcount_in < H_LIM) && (cam.vcount_in < V_LIM);

   // Index 0/1/2 holds red/green/blue, i.e. colour code minus one.
   for (genvar g = 0; g < 3; g++) begin : g_acc
      blob_accum #(.CNT_W(CNT_W)) u_acc (
         .i_clk   (clk_in),
         .i_rst   (rst_in),
         .i_clr   (w_clr),
         .i_upd   (w_upd[g]),
         .i_x     (cam.hcount_in),
         .i_y     (cam.vcount_in),
         .o_count (w_cnt[g]),
         .o_xmin  (w_xmin[g]),
         .o_xmax  (w_xmax[g]),
         .o_ymin  (w_ymin[g]),
         .o_ymax  (w_ymax[g])
      );
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_upd  = 3'b000;
      case (r_state)
         ST_ACCUM: begin
            if (w_in_area) begin
               case (w_class)
                  DET_R:   w_upd = 3'b001;
                  DET_G:   w_upd = 3'b010;
                  DET_B:   w_upd = 3'b100;
                  default: w_upd = 3'b000;
               endcase
            end else begin
               w_upd = 3'b000;
            end
            if (r_armed && w_eof) begin
               w_next = ST_EVAL;
            end else begin
               w_next = ST_ACCUM;
            end
         end
         ST_EVAL:   w_next = ST_REPORT;
         ST_REPORT: w_next = ST_CLEAR;
         ST_CLEAR: begin
            w_clr  = 1'b1;
            w_next = ST_ACCUM;
         end
         default:   w_next = ST_ACCUM;
      endcase
   end

   // A held end-of-frame position must not retrigger, so arming needs a non-EOF cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_armed <= 1'b0;
      end else if (r_state == ST_CLEAR) begin
         r_armed <= 1'b0;
      end else if (r_state == ST_ACCUM && !w_eof) begin
         r_armed <= 1'b1;
      end
   end

   always_comb begin
      w_lead = DET_R;
      w_best = w_cnt[0];
      if (w_cnt[0] >= w_cnt[1] && w_cnt[0] >= w_cnt[2]) begin
         w_lead = DET_R;
         w_best = w_cnt[0];
      end else if (w_cnt[1] >= w_cnt[2]) begin
         w_lead = DET_G;
         w_best = w_cnt[1];
      end else begin
         w_lead = DET_B;
         w_best = w_cnt[2];
      end
      w_winner = (w_best < MIN_CNT) ? DET_NONE : w_lead;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_winner <= DET_NONE;
      end else if (r_state == ST_EVAL) begin
         r_winner <= w_winner;
      end
   end

   always_comb begin
      w_sel = 2'd0;
      case (r_winner)
         DET_G:   w_sel = 2'd1;
         DET_B:   w_sel = 2'd2;
         default: w_sel = 2'd0;
      endcase
   end

   assign w_xsum = {1'b0, w_xmin[w_sel]} + {1'b0, w_xmax[w_sel]};
   assign w_ysum = {1'b0, w_ymin[w_sel]} + {1'b0, w_ymax[w_sel]};
   assign w_xmid = X_W'(w_xsum >> 1);
   assign w_ymid = Y_W'(w_ysum >> 1);

   // Track coordinates only move when a colour actually wins.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_detected   <= DET_NONE;
         r_xtrack     <= '0;
         r_ytrack     <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= (r_state == ST_REPORT);
         if (r_state == ST_REPORT) begin
            r_detected <= r_winner;
            if (r_winner != DET_NONE) begin
               r_xtrack <= w_xmid;
               r_ytrack <= w_ymid;
            end
         end
      end
   end

   assign cam.detected       = r_detected;
   assign cam.xtrack         = r_xtrack;
   assign cam.ytrack         = r_ytrack;
   assign cam.frame_done_out = r_frame_done;

endmodule

// File: tb/tb_color_blob_detector.sv
// Directed and random frames against two detectors (default, and CNT_W=4 /
// MIN_PIXELS=8) checked against a per-frame reference model.
module tb_color_blob_detector;

   logic clk_in;
   logic rst_in;

   color_blob_detector_if cam_a ();
   color_blob_detector_if cam_b ();

   color_blob_detector dut_a (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .cam    (cam_a.slave)
   );

   color_blob_detector #(.CNT_W(4), .MIN_PIXELS(8)) dut_b (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .cam    (cam_b.slave)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      int x;
      int y;
      int r;
      int g;
      int b;
      bit v;
   } pix_t;

   pix_t        frame_q[$];
   int          cw_p   [2];
   int          minp_p [2];
   int          cur_det[2];
   int          cur_x  [2];
   int          cur_y  [2];
   int          nxt_det[2];
   int          nxt_x  [2];
   int          nxt_y  [2];
   logic [31:0] od[2];
   logic [31:0] ox[2];
   logic [31:0] oy[2];
   logic [31:0] of[2];
   int          n_err;
   int          n_chk;

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input int exp);
      n_chk++;
      assert (obs === 32'(exp)) else begin
         n_err++;
         $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
      end
   endtask

   task automatic snap();
      od[0] = 32'(cam_a.detected);
      ox[0] = 32'(cam_a.xtrack);
      oy[0] = 32'(cam_a.ytrack);
      of[0] = 32'(cam_a.frame_done_out);
      od[1] = 32'(cam_b.detected);
      ox[1] = 32'(cam_b.xtrack);
      oy[1] = 32'(cam_b.ytrack);
      of[1] = 32'(cam_b.frame_done_out);
   endtask

   task automatic drive(input int x, input int y, input int r, input int g, input int b, input bit v);
      cam_a.hcount_in      = 11'(x);
      cam_a.vcount_in      = 10'(y);
      cam_a.pixel_in       = {8'(r), 8'(g), 8'(b)};
      cam_a.pixel_valid_in = v;
      cam_b.hcount_in      = 11'(x);
      cam_b.vcount_in      = 10'(y);
      cam_b.pixel_in       = {8'(r), 8'(g), 8'(b)};
      cam_b.pixel_valid_in = v;
      @(posedge clk_in);
      #1;
   endtask

   task automatic put(input int x, input int y, input int r, input int g, input int b, input bit v);
      pix_t p;
      p.x = x; p.y = y; p.r = r; p.g = g; p.b = b; p.v = v;
      frame_q.push_back(p);
      drive(x, y, r, g, b, v);
   endtask

   task automatic rect(input int x0, input int x1, input int y0, input int y1,
                       input int r, input int g, input int b);
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++)
            put(xx, yy, r, g, b, 1'b1);
   endtask

   task automatic idle(input bit hold_eof);
      if (hold_eof) drive(0, 768, 0, 0, 0, 1'b0);
      else          drive(1100, 0, 0, 0, 0, 1'b0);
   endtask

   // Reference: filter, classify, count with saturation, box, pick winner.
   task automatic eval_model(input int d);
      int cnt[3];
      int xmn[3];
      int xmx[3];
      int ymn[3];
      int ymx[3];
      int sat;
      int c;
      int win;
      sat = (1 << cw_p[d]) - 1;
      for (int i = 0; i < 3; i++) begin
         cnt[i] = 0; xmn[i] = 100000; xmx[i] = -1; ymn[i] = 100000; ymx[i] = -1;
      end
      foreach (frame_q[k]) begin
         if (frame_q[k].v && frame_q[k].x < 1024 && frame_q[k].y < 768) begin
            c = -1;
            if (frame_q[k].r >= 160 && frame_q[k].g <= 80 && frame_q[k].b <= 80) c = 0;
            if (frame_q[k].g >= 160 && frame_q[k].r <= 80 && frame_q[k].b <= 80) c = 1;
            if (frame_q[k].b >= 160 && frame_q[k].r <= 80 && frame_q[k].g <= 80) c = 2;
            if (c >= 0) begin
               if (cnt[c] < sat) cnt[c]++;
               if (frame_q[k].x < xmn[c]) xmn[c] = frame_q[k].x;
               if (frame_q[k].x > xmx[c]) xmx[c] = frame_q[k].x;
               if (frame_q[k].y < ymn[c]) ymn[c] = frame_q[k].y;
               if (frame_q[k].y > ymx[c]) ymx[c] = frame_q[k].y;
            end
         end
      end
      win = 0;
      if (cnt[1] > cnt[win]) win = 1;
      if (cnt[2] > cnt[win]) win = 2;
      if (cnt[win] >= minp_p[d]) begin
         nxt_det[d] = win + 1;
         nxt_x[d]   = (xmn[win] + xmx[win]) / 2;
         nxt_y[d]   = (ymn[win] + ymx[win]) / 2;
      end else begin
         nxt_det[d] = 0;
         nxt_x[d]   = cur_x[d];
         nxt_y[d]   = cur_y[d];
      end
   endtask

   task automatic end_frame(input bit hold_eof, input string tag);
      for (int d = 0; d < 2; d++) eval_model(d);
      drive(0, 768, 0, 0, 0, 1'b0);
      idle(hold_eof);
      snap();
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_early_done"}, d, of[d], 0);
         chk({tag, "_early_det"},  d, od[d], cur_det[d]);
      end
      idle(hold_eof);
      snap();
      for (int d = 0; d < 2; d++) begin
         cur_det[d] = nxt_det[d];
         cur_x[d]   = nxt_x[d];
         cur_y[d]   = nxt_y[d];
         chk({tag, "_det"},  d, od[d], cur_det[d]);
         chk({tag, "_x"},    d, ox[d], cur_x[d]);
         chk({tag, "_y"},    d, oy[d], cur_y[d]);
         chk({tag, "_done"}, d, of[d], 1);
      end
      idle(hold_eof);
      snap();
      for (int d = 0; d < 2; d++) chk({tag, "_done_drop"}, d, of[d], 0);
      if (hold_eof) begin
         for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            snap();
            for (int d = 0; d < 2; d++) chk({tag, "_no_retrig"}, d, of[d], 0);
         end
      end
      frame_q.delete();
   endtask

   task automatic rand_frame(input int n);
      int x;
      int y;
      int sel;
      int dom;
      int o1;
      int o2;
      bit v;
      for (int i = 0; i < n; i++) begin
         x   = $urandom_range(0, 1100);
         y   = $urandom_range(0, 767);
         sel = $urandom_range(0, 3);
         dom = $urandom_range(150, 255);
         o1  = $urandom_range(0, 90);
         o2  = $urandom_range(0, 90);
         v   = ($urandom_range(0, 9) != 0);
         case (sel)
            0:       put(x, y, dom, o1, o2, v);
            1:       put(x, y, o1, dom, o2, v);
            2:       put(x, y, o1, o2, dom, v);
            default: put(x, y, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), v);
         endcase
      end
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      cw_p[0] = 20; cw_p[1] = 4;
      minp_p[0] = 64; minp_p[1] = 8;
      for (int d = 0; d < 2; d++) begin
         cur_det[d] = 0; cur_x[d] = 0; cur_y[d] = 0;
      end

      rst_in = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b0);
      snap();
      for (int d = 0; d < 2; d++) begin
         chk("reset_det",  d, od[d], 0);
         chk("reset_x",    d, ox[d], 0);
         chk("reset_y",    d, oy[d], 0);
         chk("reset_done", d, of[d], 0);
      end
      rst_in = 1'b0;
      idle(1'b0);

      rect(100, 199, 50, 149, 255, 0, 0);
      put(5, 5, 0, 0, 0, 1'b1);
      end_frame(1'b0, "red_square");

      for (int i = 0; i < 63; i++) put(10 + i, 20, 255, 0, 0, 1'b1);
      end_frame(1'b0, "under_min");

      rect(500, 509, 600, 609, 0, 255, 0);
      rect(300, 319, 200, 219, 0, 0, 255);
      end_frame(1'b0, "green_blue");

      rect(700, 709, 10, 19, 255, 0, 0);
      rect(720, 729, 30, 39, 0, 255, 0);
      end_frame(1'b0, "tie");

      for (int i = 0; i < 70; i++) begin
         put(400 + i, 300, 255, 0, 0, 1'b0);
         put(400 + i, 301, 200, 200, 0, 1'b1);
         put(1100, 300 + i, 255, 0, 0, 1'b1);
      end
      end_frame(1'b0, "filter");

      for (int i = 0; i < 64; i++) put(1023, 704 + i, 160, 80, 80, 1'b1);
      for (int i = 0; i < 100; i++) put(900, i, 159, 0, 0, 1'b1);
      for (int i = 0; i < 50; i++) put(901, i, 160, 81, 0, 1'b1);
      end_frame(1'b1, "thresh_hold");

      for (int i = 0; i < 20; i++) put(50 + i, 60, 0, 0, 255, 1'b1);
      for (int i = 0; i < 14; i++) put(50 + i, 61, 255, 0, 0, 1'b1);
      end_frame(1'b0, "saturate");

      for (int f = 0; f < 3; f++) begin
         rand_frame(300 + 100 * f);
         end_frame(1'b0, "random");
      end

      rect(600, 609, 100, 107, 255, 0, 0);
      #2;
      rst_in = 1'b1;
      #1;
      snap();
      for (int d = 0; d < 2; d++) begin
         cur_det[d] = 0; cur_x[d] = 0; cur_y[d] = 0;
         chk("async_rst_det",  d, od[d], 0);
         chk("async_rst_x",    d, ox[d], 0);
         chk("async_rst_y",    d, oy[d], 0);
         chk("async_rst_done", d, of[d], 0);
      end
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      frame_q.delete();
      rect(40, 49, 700, 709, 0, 255, 0);
      end_frame(1'b0, "post_reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
